trace_checker: RTL
==================

Name: trace_checker

Overview:
Synthesisable, parametrised per-retire trace checker for the single-cycle core. It compares the core's observed PC, Instr, ALUResult, Result and RegWrite against an expected-trace memory, one entry per retired instruction. A per-field check mask in each entry replaces hand-written don't-care defaults. It counts mismatches with saturation and captures the first failure. It sits beside top in benches and FPGA bring-up, and is fed by probe wires from the datapath.

Parameters:
XLEN, 32, datapath width of the observed fields
DEPTH, 32, number of expected-trace entries (power of two, ≥2)
AW, $clog2(DEPTH), entry index width
ERR_W, 16, error counter width
SKIP_BEATS, 2, obs_valid beats discarded after start (pipeline/reset warm-up)
STOP_ON_ERR, 0, 1 = finish on the first mismatch; 0 = run all DEPTH entries

Ports:
CLK  in  1  clock
RST  in  1  asynchronous, active-high reset
start  in  1  arm checker (one-cycle pulse)
obs_valid  in  1  one instruction retires this cycle
obs_pc  in  XLEN  observed PC
obs_instr  in  32  observed instruction
obs_alu  in  XLEN  observed ALUResult
obs_result  in  XLEN  observed writeback Result
obs_regwrite  in  1  observed RegWrite
exp_we  in  1  expected-memory write strobe
exp_addr  in  AW  expected-memory write index
exp_wdata  in  EW  entry {mask[4:0], pc, instr, alu, result, regwrite}; EW = 3*XLEN+32+1+5; mask bit order {pc,instr,alu,result,regwrite}
busy  out  1  in SKIP or RUN
done  out  1  check finished (level, held until start or RST)
pass  out  1  done && err_count==0
err_pulse  out  1  one-cycle pulse per mismatching entry
err_count  out  ERR_W  mismatching entries, saturating
first_err_idx  out  AW  entry index of first mismatch
first_err_field  out  5  per-field mismatch bits of first mismatch, same order as mask

Behaviour:
- Reset (async): state IDLE; busy, done, pass, err_pulse, err_count, first_err_idx and first_err_field are 0; the index and skip counters are 0. Memory contents are not reset.
- States: IDLE, SKIP, RUN, DRAIN, DONE.
- IDLE/DONE: when exp_we=1, write exp_wdata to mem[exp_addr]. exp_we is ignored in SKIP, RUN and DRAIN. obs_valid is ignored.
- start in IDLE or DONE: clear err_count, first_err_*, index and done. Go to SKIP, or directly to RUN if SKIP_BEATS==0. start in SKIP, RUN or DRAIN is ignored.
- SKIP: count obs_valid beats. On beat SKIP_BEATS, go to RUN. That beat is not checked.
- RUN: each obs_valid beat registers the observed fields and issues a synchronous read of mem[idx]; idx then increments.
- Compare stage (one cycle later): field_mis[k] = mask[k] && (obs≠exp). Entry mismatch = |field_mis.
- err_pulse is asserted in the cycle after the accepted beat, i.e. latency 1.
- On a mismatch, err_count increments and saturates at 2^ERR_W−1.
- If the mismatch is the first since start, latch first_err_idx and first_err_field.
- When the beat with idx=DEPTH−1 is accepted, go to DRAIN. Further obs_valid beats are ignored.
- DRAIN: the last compare completes; next state DONE.
- STOP_ON_ERR=1: the first mismatch moves the FSM to DONE in the compare cycle. Any beat accepted in that same cycle is discarded and is not counted.
- DONE: done=1 and pass=(err_count==0). Outputs hold until start or RST.
- An entry with mask=0 always matches.
- RST asserted mid-run aborts immediately to the reset state.

Decomposition:
- Package trace_chk_pkg holds:
  - the state encoding;
  - field bit-position constants for the mask (F_PC=4, F_INSTR=3, F_ALU=2, F_RES=1, F_RW=0);
  - the EW width expression.
- One sub-module, trace_exp_ram: DEPTH×EW, one write port, one synchronous read port, no reset.

Test Plan:
- Match case: load entry0 {mask=1F, pc=0, instr=00100113, alu=0, res=0, rw=1} and entry1 {1F, 4, 00030333, 4, 4, 0}, DEPTH=2, SKIP_BEATS=2. start, then 4 matching beats → no err_pulse; done=1 and pass=1 one cycle after DRAIN; err_count=0.
- Mismatch capture: entry1 expects alu=4, drive alu=5 → err_pulse one cycle after beat 1; err_count=1; first_err_idx=1; first_err_field=5'b00100; pass=0.
- Mask: repeat the previous case with entry1 mask=5'b11011 → no error; pass=1.
- Stop mode: STOP_ON_ERR=1, DEPTH=32, mismatch at idx 3 → done in the compare cycle; later beats ignored; err_count=1.
- Saturation: ERR_W=2, all 32 entries mismatching → err_count=3; first_err_idx=0.
- Reset and gating: assert RST at idx 10 → all outputs 0 and state IDLE. Memory is preserved: a rerun without reloading passes. start and exp_we applied during RUN have no effect.

Source files
------------

// File: rtl/trace_chk_pkg.sv
// trace_chk_pkg: state encoding, mask bit positions and entry width for the trace checker
package trace_chk_pkg;
  typedef enum logic [2:0] {IDLE, SKIP, RUN, DRAIN, DONE} state_t;
  localparam int F_PC = 4;
  localparam int F_INSTR = 3;
  localparam int F_ALU = 2;
  localparam int F_RES = 1;
  localparam int F_RW = 0;
  function automatic int ew(input int xlen);
    return 3 * xlen + 32 + 1 + 5;
  endfunction
endpackage

// File: rtl/trace_exp_ram.sv
// trace_exp_ram: expected-trace storage, one write port and one registered read port
module trace_exp_ram #(
  parameter int DEPTH = 32,
  parameter int W = 134,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/trace_checker.sv
// trace_checker: compares retired-instruction probes against an expected trace with per-field masks
module trace_checker import trace_chk_pkg::*; #(
  parameter int XLEN = 32,
  parameter int DEPTH = 32,
  parameter int AW = $clog2(DEPTH),
  parameter int ERR_W = 16,
  parameter int SKIP_BEATS = 2,
  parameter int STOP_ON_ERR = 0,
  localparam int EW = ew(XLEN)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             obs_valid,
  input  logic [XLEN-1:0]  obs_pc,
  input  logic [31:0]      obs_instr,
  input  logic [XLEN-1:0]  obs_alu,
  input  logic [XLEN-1:0]  obs_result,
  input  logic             obs_regwrite,
  input  logic             exp_we,
  input  logic [AW-1:0]    exp_addr,
  input  logic [EW-1:0]    exp_wdata,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [AW-1:0]    first_err_idx,
  output logic [4:0]       first_err_field
);
  localparam int SW = SKIP_BEATS > 1 ? $clog2(SKIP_BEATS) : 1;
  state_t state, nxt;
  logic [AW-1:0] idx, cmp_idx;
  logic [SW-1:0] skip_cnt;
  logic cmp_v, o_rw, e_rw, mis, start_ok, accept, last;
  logic [XLEN-1:0] o_pc, o_alu, o_res, e_pc, e_alu, e_res;
  logic [31:0] o_instr, e_instr;
  logic [4:0] e_mask, field_mis;
  logic [EW-1:0] rdata;
  logic [ERR_W-1:0] err_next;
  trace_exp_ram #(.DEPTH(DEPTH), .W(EW), .AW(AW)) u_ram (
    .clk(CLK), .we(exp_we && (state == IDLE || state == DONE)), .waddr(exp_addr),
    .wdata(exp_wdata), .re(accept), .raddr(idx), .rdata(rdata)
  );
  always_comb begin
    {e_mask, e_pc, e_instr, e_alu, e_res, e_rw} = rdata;
    field_mis = '0;
    field_mis[F_PC] = e_mask[F_PC] && o_pc != e_pc;
    field_mis[F_INSTR] = e_mask[F_INSTR] && o_instr != e_instr;
    field_mis[F_ALU] = e_mask[F_ALU] && o_alu != e_alu;
    field_mis[F_RES] = e_mask[F_RES] && o_res != e_res;
    field_mis[F_RW] = e_mask[F_RW] && o_rw != e_rw;
    mis = cmp_v && |field_mis;
    err_pulse = mis;
    start_ok = start && (state == IDLE || state == DONE);
    // in stop mode a beat arriving alongside the first mismatch is dropped
    accept = state == RUN && obs_valid && !(STOP_ON_ERR != 0 && mis);
    last = accept && idx == AW'(DEPTH - 1);
    nxt = start_ok ? (SKIP_BEATS == 0 ? RUN : SKIP)
        : (STOP_ON_ERR != 0 && mis) ? DONE
        : (state == SKIP && obs_valid && int'(skip_cnt) == SKIP_BEATS - 1) ? RUN
        : last ? DRAIN
        : state == DRAIN ? DONE : state;
    err_next = start_ok ? '0 : (mis && err_count != '1) ? err_count + 1'b1 : err_count;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      idx <= '0;
      skip_cnt <= '0;
      cmp_v <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      first_err_idx <= '0;
      first_err_field <= '0;
    end else begin
      state <= nxt;
      busy <= nxt == SKIP || nxt == RUN;
      done <= nxt == DONE;
      pass <= nxt == DONE && err_next == '0;
      err_count <= err_next;
      cmp_v <= accept;
      if (state == SKIP && obs_valid) skip_cnt <= skip_cnt + 1'b1;
      if (accept) idx <= idx + 1'b1;
      // err_count saturates and never returns to zero, so zero means no mismatch yet
      if (mis && err_count == '0) begin
        first_err_idx <= cmp_idx;
        first_err_field <= field_mis;
      end
      if (start_ok) begin
        idx <= '0;
        skip_cnt <= '0;
        first_err_idx <= '0;
        first_err_field <= '0;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (accept) begin
      cmp_idx <= idx;
      o_pc <= obs_pc;
      o_instr <= obs_instr;
      o_alu <= obs_alu;
      o_res <= obs_result;
      o_rw <= obs_regwrite;
    end
  end
endmodule
